// File: rtl/lcd_command_responder.sv
// Responder end of the CPU-to-LCD command link: initialises an HD44780 16x2 panel, then renders
// one full frame (instruction/register/value, splash, or blank) per accepted lcd_start.
module lcd_command_responder #(
  parameter int unsigned T_POWERUP = 1000000,
  parameter int unsigned T_EN      = 16,
  parameter int unsigned T_CMD     = 2500,
  parameter int unsigned T_CLEAR   = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_start,
  input  logic [2:0]  lcd_opcode,
  input  logic [3:0]  lcd_reg_index,
  input  logic [15:0] lcd_value,
  input  logic        show_splash_req,
  input  logic        force_blank_req,
  output logic        lcd_busy,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on
);

  typedef enum logic [2:0] {StPwrWait, StInit, StIdle, StConvert, StSend, StDone} state_e;
  typedef enum logic [1:0] {PhSetup, PhEn, PhWait} phase_e;
  typedef enum logic [1:0] {ModeNormal, ModeSplash, ModeBlank} mode_e;

  state_e      state_q;
  phase_e      phase_q;
  mode_e       mode_q;
  logic [31:0] cnt_q;
  logic [5:0]  idx_q;
  logic [2:0]  opcode_q;
  logic [3:0]  reg_q;
  logic        neg_q;
  logic [15:0] bin_q;
  logic [19:0] bcd_q;
  logic        busy_q, rs_q, en_q, on_q;
  logic [7:0]  data_q;

  // Add-3 correction applied to every BCD digit before each double-dabble shift.
  function automatic logic [19:0] dd_adjust(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] init_byte(input logic [5:0] idx);
    logic [7:0] b;
    case (idx)
      6'd0:    b = 8'h38;
      6'd1:    b = 8'h0C;
      6'd2:    b = 8'h01;
      default: b = 8'h06;
    endcase
    return b;
  endfunction

  // Frame layout: 0x0C, 0x80, 16 line-1 chars (idx 2-17), 0xC0, 16 line-2 chars (idx 19-34).
  function automatic logic [8:0] frame_byte(input mode_e mode, input logic [5:0] idx,
                                            input logic [2:0] opc, input logic [3:0] rix,
                                            input logic neg, input logic [19:0] bcd);
    logic [55:0]  mn;
    logic [127:0] sp1, sp2;
    logic [3:0]   col, col_r, ones;
    logic [2:0]   mi, di;
    logic [7:0]   ch;
    logic [8:0]   res;
    sp1 = {{3{8'h20}}, "MINI", {2{8'h20}}, "CPU", {4{8'h20}}};
    sp2 = {{2{8'h20}}, "READY...", {6{8'h20}}};
    case (opc)
      3'd0:    mn = {"LOAD", {3{8'h20}}};
      3'd1:    mn = {"ADD", {4{8'h20}}};
      3'd2:    mn = {"ADDI", {3{8'h20}}};
      3'd3:    mn = {"SUB", {4{8'h20}}};
      3'd4:    mn = {"SUBI", {3{8'h20}}};
      3'd5:    mn = {"MUL", {4{8'h20}}};
      3'd6:    mn = {"CLEAR", {2{8'h20}}};
      default: mn = "DISPLAY";
    endcase
    ones = (rix >= 4'd10) ? rix - 4'd10 : rix;
    ch   = 8'h20;
    col  = 4'd0;
    if (mode == ModeBlank) begin
      res = (idx == 6'd0) ? 9'h008 : 9'h001;
    end else if (idx == 6'd0) begin
      res = 9'h00C;
    end else if (idx == 6'd1) begin
      res = 9'h080;
    end else if (idx == 6'd18) begin
      res = 9'h0C0;
    end else begin
      col   = (idx < 6'd18) ? 4'(idx - 6'd2) : 4'(idx - 6'd19);
      col_r = 4'd15 - col;
      mi    = 3'(4'd6 - col);
      di    = 3'(col_r);
      if (idx < 6'd18) begin
        if (mode == ModeSplash) ch = sp1[{col_r, 3'b000} +: 8];
        else if (col < 4'd7)    ch = mn[{mi, 3'b000} +: 8];
        else if (col == 4'd13)  ch = "R";
        else if (col == 4'd14)  ch = (rix >= 4'd10) ? "1" : "0";
        else if (col == 4'd15)  ch = {4'h3, ones};
      end else begin
        if (mode == ModeSplash) ch = sp2[{col_r, 3'b000} +: 8];
        else if (col == 4'd10)  ch = neg ? "-" : "+";
        else if (col > 4'd10)   ch = {4'h3, bcd[{di, 2'b00} +: 4]};
      end
      res = {1'b1, ch};
    end
    return res;
  endfunction

  logic [31:0] wait_len;
  logic [5:0]  last_idx;
  logic [8:0]  next_byte;
  logic [15:0] mag;
  logic [19:0] bcd_adj;
  mode_e       req_mode;

  always_comb begin
    wait_len = (!rs_q && data_q == 8'h01) ? T_CLEAR : T_CMD;
    last_idx = (state_q == StInit) ? 6'd3 : ((mode_q == ModeBlank) ? 6'd1 : 6'd34);
    if (state_q == StInit) next_byte = {1'b0, init_byte(idx_q + 6'd1)};
    else next_byte = frame_byte(mode_q, idx_q + 6'd1, opcode_q, reg_q, neg_q, bcd_q);
    mag      = lcd_value[15] ? (~lcd_value + 16'd1) : lcd_value;
    bcd_adj  = dd_adjust(bcd_q);
    req_mode = force_blank_req ? ModeBlank : (show_splash_req ? ModeSplash : ModeNormal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StPwrWait;
      phase_q  <= PhSetup;
      mode_q   <= ModeNormal;
      cnt_q    <= '0;
      idx_q    <= '0;
      opcode_q <= '0;
      reg_q    <= '0;
      neg_q    <= 1'b0;
      bin_q    <= '0;
      bcd_q    <= '0;
      busy_q   <= 1'b1;
      data_q   <= 8'h00;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      on_q     <= 1'b1;
    end else begin
      case (state_q)
        StPwrWait: begin
          if (cnt_q == T_POWERUP - 32'd1) begin
            state_q <= StInit;
            phase_q <= PhSetup;
            cnt_q   <= '0;
            idx_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h38;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StIdle: begin
          if (lcd_start) begin
            busy_q   <= 1'b1;
            mode_q   <= req_mode;
            opcode_q <= lcd_opcode;
            reg_q    <= lcd_reg_index;
            neg_q    <= lcd_value[15];
            cnt_q    <= '0;
            idx_q    <= '0;
            phase_q  <= PhSetup;
            if (req_mode != ModeBlank) on_q <= 1'b1;
            if (req_mode == ModeNormal) begin
              state_q <= StConvert;
              bin_q   <= mag;
              bcd_q   <= '0;
            end else begin
              state_q <= StSend;
              rs_q    <= 1'b0;
              data_q  <= (req_mode == ModeBlank) ? 8'h08 : 8'h0C;
            end
          end
        end
        StConvert: begin
          bcd_q <= {bcd_adj[18:0], bin_q[15]};
          bin_q <= {bin_q[14:0], 1'b0};
          if (cnt_q == 32'd15) begin
            state_q <= StSend;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h0C;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StInit, StSend: begin
          case (phase_q)
            PhSetup: begin
              en_q    <= 1'b1;
              phase_q <= PhEn;
              cnt_q   <= '0;
            end
            PhEn: begin
              if (cnt_q == T_EN - 32'd1) begin
                en_q    <= 1'b0;
                phase_q <= PhWait;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 32'd1;
              end
            end
            PhWait: begin
              if (cnt_q == wait_len - 32'd1) begin
                cnt_q <= '0;
                if (idx_q == last_idx) begin
                  if (state_q == StInit) begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                  end else begin
                    state_q <= StDone;
                    if (mode_q == ModeBlank) on_q <= 1'b0;
                  end
                end else begin
                  idx_q          <= idx_q + 6'd1;
                  {rs_q, data_q} <= next_byte;
                  phase_q        <= PhSetup;
                end
              end else begin
                cnt_q <= cnt_q + 32'd1;
              end
            end
            default: phase_q <= PhSetup;
          endcase
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StPwrWait;
      endcase
    end
  end

  assign lcd_busy = busy_q;
  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_q;
  assign lcd_on   = on_q;

endmodule
